// File: rtl/seq_counter_prog.sv
// Programmable-sequence counter: an index walks a writable code table of DEPTH
// entries and presents the selected WIDTH-bit code on Q.
module seq_counter_prog #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 16,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int LW = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             DIR,
   input  logic             MODE,
   input  logic             CLR,
   input  logic [LW-1:0]    LEN,
   input  logic             WR_EN,
   input  logic [AW-1:0]    WR_ADDR,
   input  logic [WIDTH-1:0] WR_DATA,
   output logic [WIDTH-1:0] Q,
   output logic [AW-1:0]    IDX,
   output logic             TC,
   output logic             DONE
);

   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic [WIDTH-1:0] table_r [DEPTH];
   logic [AW-1:0]    idx_r;
   logic [AW-1:0]    idx_nxt_s;
   logic             done_r;
   logic             done_nxt_s;
   logic [LW-1:0]    len_eff_s;
   logic [AW-1:0]    last_s;
   logic             at_term_s;
   logic             wr_ok_s;

   // Clamp the requested length into 1..DEPTH and derive the last active index.
   always_comb begin
      len_eff_s = LEN;
      if (LEN == LW'(0)) begin
         len_eff_s = LW'(1);
      end else if (LEN > DEPTH_L) begin
         len_eff_s = DEPTH_L;
      end else begin
         len_eff_s = LEN;
      end
      last_s = AW'(len_eff_s - LW'(1));
   end

   // Terminal detection; forward uses >= so a shrunk LEN still counts as terminal.
   always_comb begin
      at_term_s = 1'b0;
      if (DIR) begin
         at_term_s = (LW'(idx_r) >= (len_eff_s - LW'(1)));
      end else begin
         at_term_s = (idx_r == AW'(0));
      end
   end

   // Next index / done flag: CLR beats stepping, DONE freezes stepping.
   always_comb begin
      idx_nxt_s  = idx_r;
      done_nxt_s = done_r;
      if (CLR) begin
         idx_nxt_s  = AW'(0);
         done_nxt_s = 1'b0;
      end else if (EN && !done_r) begin
         if (!at_term_s) begin
            if (DIR) begin
               idx_nxt_s = idx_r + AW'(1);
            end else begin
               idx_nxt_s = idx_r - AW'(1);
            end
         end else if (!MODE) begin
            if (DIR) begin
               idx_nxt_s = AW'(0);
            end else begin
               idx_nxt_s = last_s;
            end
         end else begin
            idx_nxt_s  = idx_r;
            done_nxt_s = 1'b1;
         end
      end else begin
         idx_nxt_s  = idx_r;
         done_nxt_s = done_r;
      end
   end

   // Index and done registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         idx_r  <= AW'(0);
         done_r <= 1'b0;
      end else begin
         idx_r  <= idx_nxt_s;
         done_r <= done_nxt_s;
      end
   end

   assign wr_ok_s = WR_EN && (LW'(WR_ADDR) < DEPTH_L);

   // Code table: reset loads the identity sequence so the block starts as a binary counter.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            table_r[i] <= WIDTH'(i);
         end
      end else begin
         if (wr_ok_s) begin
            table_r[WR_ADDR] <= WR_DATA;
         end
      end
   end

   assign Q    = table_r[idx_r];
   assign IDX  = idx_r;
   assign DONE = done_r;
   assign TC   = EN & ~done_r & at_term_s;

endmodule

// File: doc/seq_counter_prog.md
# seq_counter_prog

Parametrised programmable-sequence counter: steps an index through a register table of up to DEPTH entries and presents the selected WIDTH-bit code on Q. Arbitrary code sequences (Gray, BCD, excess-3, irregular), previously built as fixed flip-flop excitation logic per sequence, now come from one block. Adds run-time reprogramming, selectable sequence length, bidirectional stepping, wrap or one-shot mode, and terminal-count/done flags. Sits beside the flip-flop counter library as the general-purpose sequence source for the counter test benches.

## Interface
- WIDTH, 4, bits per sequence code (1..16)
- DEPTH, 16, table entries (2..256); AW = clog2(DEPTH), LW = clog2(DEPTH+1)
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, asynchronous, active-high
- EN  in  1  step enable
- DIR  in  1  1 = forward (index +1), 0 = reverse (index -1)
- MODE  in  1  0 = wrap, 1 = one-shot
- CLR  in  1  synchronous restart: IDX<=0, DONE<=0; table untouched
- LEN  in  LW  active sequence length; 0 treated as 1, >DEPTH treated as DEPTH (LEN_eff)
- WR_EN  in  1  table write strobe
- WR_ADDR  in  AW  table write address; addresses >= DEPTH ignored
- WR_DATA  in  WIDTH  table write data
- Q  out  WIDTH  table[IDX], combinational from registers
- IDX  out  AW  current index, registered
- TC  out  1  terminal count, combinational
- DONE  out  1  one-shot completion flag, registered

## Operation
- Reset (async, immediate): IDX=0, DONE=0, table[i] = i mod 2^WIDTH for every i, so Q=0. Out of reset the block behaves as a plain binary up-counter over LEN_eff entries.
- Terminal position: IDX >= LEN_eff-1 when DIR=1; IDX == 0 when DIR=0.
- TC = EN & ~DONE & at terminal position. Not registered; follows EN/DIR/LEN in the same cycle.
- Step (EN=1, DONE=0, CLR=0), per rising edge:
  - not at terminal: IDX <= IDX+1 (DIR=1) or IDX-1 (DIR=0)
  - at terminal, MODE=0: IDX <= 0 (forward) or LEN_eff-1 (reverse)
  - at terminal, MODE=1: IDX holds; DONE <= 1
- DONE=1: EN ignored in both directions; IDX holds until CLR or RST.
- EN=0: IDX and DONE hold.
- Priority: RST > CLR > step. CLR with EN=1 yields IDX=0, no step that edge.
- LEN reduced below IDX+1: IDX is at/over terminal (forward). Next forward step wraps to 0 (MODE=0) or holds and sets DONE (MODE=1). Next reverse step decrements normally.
- Writes: table[WR_ADDR] <= WR_DATA on the edge, independent of stepping, CLR and DONE. A write to the entry at the current (post-edge) IDX is visible on Q right after that edge. Write plus step in the same edge: Q shows the new IDX entry including that edge's write.
- Table entries are not cleared by CLR, only by RST.

## Timing
- IDX, DONE: one edge from EN sample to update. Q follows IDX with only combinational read delay.
- TC asserts in the cycle where the wrap/DONE edge will occur. DONE rises on that edge.
- Q is not glitch-free across a table write. Downstream samples Q on CLK.
- RST deassertion is synchronised externally. First step can occur on the first edge after RST falls.

## Test plan
- Default sequence: RST, LEN=16, DIR=1, MODE=0, EN=1 for 17 edges -> Q counts 0..15 then 0. TC=1 only while IDX=15.
- Program 0,1,3,2,6,7,5,4 into entries 0..7, LEN=8, MODE=0 -> Q = Gray sequence, wraps 4->0. With DIR=0 from IDX=0, Q goes 0->4->5->7.
- One-shot: LEN=5, MODE=1, DIR=1, EN=1 from IDX=0 -> IDX 0..4. DONE rises on the 5th edge, IDX stays 4 under further EN and DIR toggles. CLR -> IDX=0, DONE=0 next edge.
- LEN shrink: at IDX=9, set LEN=4, MODE=0, DIR=1 -> next edge IDX=0. Repeat with DIR=0 -> IDX=8.
- Reset mid-run: assert RST asynchronously between edges at IDX=6 after custom writes -> IDX=0, DONE=0, Q=0 immediately. table[3] reads back 3.
- Write collision: at IDX=2, DIR=1, EN=1, write WR_ADDR=3, WR_DATA=0xA on the same edge -> after the edge IDX=3, Q=0xA. LEN=0 with EN=1 -> IDX stays 0, TC=1 continuously.
